risc_toy_fetch_queue: RTL and testbench
=======================================

# risc_toy_fetch_queue

Instruction fetch front end for the RISC_TOY pipeline: owns the fetch PC, drives the instruction memory port (IADDR/IREQ/INSTR), and buffers returned words in a small prefetch FIFO that feeds the FD pipeline register. It decouples memory read latency from decode stalls and absorbs taken-branch/jump redirects from EX by flushing in-flight and buffered instructions.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] ignored
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-high
- REDIRECT  in  1  taken branch/jump from EX; flush and refetch
- REDIRECT_PC  in  32  byte target address; bits [1:0] ignored
- IADDR  out  30  word address to instruction memory (= fetch PC [31:2])
- IREQ  out  1  instruction memory read request
- INSTR  in  32  read data; valid exactly 1 cycle after the request cycle
- F_VALID  out  1  head entry valid
- F_INSTR  out  32  head instruction
- F_PCADD4  out  32  byte address of head instruction + 4
- F_READY  in  1  FD register accepts head this cycle (deasserted when FDWrite is low)

## Operation
- State: fpc (30 b), FIFO storage (DEPTH × 62 b: instr + word addr+1), rd/wr pointers, count (clog2(DEPTH)+1 b), inflight flag, inflight_addr (30 b).
- Issue: IREQ = !REDIRECT && (count + inflight < DEPTH). IADDR = fpc always. On issue: fpc ← fpc+1 (wraps 2^30−1 → 0), inflight ← 1, inflight_addr ← fpc; else inflight ← 0.
- Return: cycle after issue, if inflight && !REDIRECT, push {INSTR, inflight_addr+1}. Space is reserved at issue, so a push never overflows.
- Pop: F_VALID && F_READY && !REDIRECT → rd pointer advances, count decrements. Push and pop in same cycle: count unchanged, legal at full and empty.
- F_PCADD4 = {stored word addr+1, 2'b00}; wraps modulo 2^32.
- REDIRECT (priority over all): count ← 0, pointers ← 0, inflight ← 0 (current-cycle INSTR discarded), fpc ← REDIRECT_PC[31:2], no IREQ that cycle, pop ignored.
- Outputs F_INSTR/F_PCADD4 are don't-care when F_VALID = 0 but must not be X after reset (storage reset to 0).

## Timing
- Reset values: fpc = RESET_PC[31:2], IREQ = 0 while RST high, IADDR = RESET_PC[31:2], F_VALID = 0, count = 0, inflight = 0, F_INSTR = 0, F_PCADD4 = 0.
- First IREQ in first clock edge cycle after RST deasserts.
- Latency (macro off): request cycle N, INSTR sampled edge end of N+1, F_VALID high in N+2. Redirect in cycle R → IREQ with target in R+1 → F_VALID in R+3.
- Steady state with F_READY high: one instruction per cycle after fill.
- F_READY low with queue full: IREQ held low until a pop frees a slot; pop at cycle N allows IREQ at N+1.
- RST mid-operation: immediate return to reset values; in-flight response dropped.

## Configuration
- FETCH_BYPASS_EN defined: when count = 0 and a return is pushed, head outputs are driven combinationally from INSTR/inflight_addr+1 and F_VALID asserts in the return cycle; if F_READY is also high the word is consumed and not written. Redirect latency R → F_VALID in R+2.
- Undefined: all outputs come from FIFO registers only; latencies as in Timing.

## Test plan
- Reset with RESET_PC=32'h100, F_READY=1, memory returns addr as data → IADDR 0x40,0x41,0x42…; F_VALID in 3rd cycle, F_PCADD4=32'h104, then 32'h108 each cycle.
- F_READY=0 for 10 cycles → exactly DEPTH=4 IREQs issued, count=4, IREQ low; F_READY=1 for one cycle → one IREQ next cycle, no overflow/loss.
- REDIRECT=1 with REDIRECT_PC=32'h2000 while queue holds 3 entries and one in flight → F_VALID=0 next cycle, next IADDR=0x800, first F_PCADD4=32'h2004; no stale word ever emitted.
- Pop and push same cycle at full and at count 1 → count constant, order preserved.
- REDIRECT_PC=32'hFFFF_FFFC → IADDR 0x3FFF_FFFF then 0x0; F_PCADD4 32'h0000_0000 then 32'h0000_0004.
- FETCH_BYPASS_EN defined, empty queue, F_READY=1 → F_VALID in return cycle, redirect-to-valid = 2 cycles.

Source files
------------

// File: rtl/risc_toy_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one-word reads to instruction memory and buffers
// returned words in a small prefetch FIFO. Optional same-cycle bypass under FETCH_BYPASS_EN.
module risc_toy_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [29:0] IADDR,
    output logic        IREQ,
    input  logic [31:0] INSTR,
    output logic        F_VALID,
    output logic [31:0] F_INSTR,
    output logic [31:0] F_PCADD4,
    input  logic        F_READY
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

    logic [29:0]    fpc_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           inflight_q;
    logic [29:0]    inflight_addr_q;
    logic [31:0]    instr_mem_q [DEPTH];
    logic [29:0]    addr1_mem_q [DEPTH];

    logic [OW-1:0]  occupancy;
    logic           issue;
    logic           ret;
    logic           push;
    logic           pop;
    logic           fifo_valid;
    logic [29:0]    ret_addr1;

    // Space is reserved at issue time, so an in-flight word always has a slot waiting.
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue      = !REDIRECT && (occupancy < DEPTH_O);
    assign IREQ       = issue && !RST;
    assign IADDR      = fpc_q;
    assign ret        = inflight_q && !REDIRECT;
    assign ret_addr1  = inflight_addr_q + 30'd1;
    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && F_READY && !REDIRECT;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // Empty queue: present the returning word directly; skip the write if consumed now.
    assign bypass   = ret && !fifo_valid;
    assign push     = ret && !(bypass && F_READY);
    assign F_VALID  = fifo_valid || bypass;
    assign F_INSTR  = bypass ? INSTR : instr_mem_q[rd_ptr_q];
    assign F_PCADD4 = bypass ? {ret_addr1, 2'b00} : {addr1_mem_q[rd_ptr_q], 2'b00};
`else
    assign push     = ret;
    assign F_VALID  = fifo_valid;
    assign F_INSTR  = instr_mem_q[rd_ptr_q];
    assign F_PCADD4 = {addr1_mem_q[rd_ptr_q], 2'b00};
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fpc_q           <= RESET_PC[31:2];
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                addr1_mem_q[i] <= '0;
            end
        end else if (REDIRECT) begin
            // Flush drops both buffered words and the response arriving this cycle.
            fpc_q      <= REDIRECT_PC[31:2];
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fpc_q           <= fpc_q + 30'd1;
                inflight_addr_q <= fpc_q;
            end
            if (push) begin
                instr_mem_q[wr_ptr_q] <= INSTR;
                addr1_mem_q[wr_ptr_q] <= ret_addr1;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Directed bench for risc_toy_fetch_queue (default build); the memory model returns the
// requested word address as data so each head word can be tied back to its PC.
module tb_risc_toy_fetch_queue;

    logic        CLK;
    logic        RST;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [29:0] IADDR;
    logic        IREQ;
    logic [31:0] INSTR;
    logic        F_VALID;
    logic [31:0] F_INSTR;
    logic [31:0] F_PCADD4;
    logic        F_READY;

    int n_cmp  = 0;
    int n_fail = 0;

    risc_toy_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IADDR       (IADDR),
        .IREQ        (IREQ),
        .INSTR       (INSTR),
        .F_VALID     (F_VALID),
        .F_INSTR     (F_INSTR),
        .F_PCADD4    (F_PCADD4),
        .F_READY     (F_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle-latency memory: data is the requested word address, junk when idle.
    initial INSTR = 32'h0;
    always @(posedge CLK) INSTR <= IREQ ? {2'b00, IADDR} : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Head word must be the one fetched from (F_PCADD4 - 4).
    task automatic expect_cycle(input string tag, input logic ireq, input logic [29:0] iaddr,
                                input logic fv, input logic [31:0] pc4);
        logic [29:0] head_addr;
        chk({tag, ".IREQ"}, {31'd0, IREQ}, {31'd0, ireq});
        chk({tag, ".IADDR"}, {2'b00, IADDR}, {2'b00, iaddr});
        chk({tag, ".F_VALID"}, {31'd0, F_VALID}, {31'd0, fv});
        if (fv) begin
            head_addr = pc4[31:2] - 30'd1;
            chk({tag, ".F_PCADD4"}, F_PCADD4, pc4);
            chk({tag, ".F_INSTR"}, F_INSTR, {2'b00, head_addr});
        end
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        RST         = 1'b1;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        F_READY     = 1'b1;
        #2;
        expect_cycle("rst0", 1'b0, 30'h40, 1'b0, 32'h0);
        chk("rst0.F_INSTR", F_INSTR, 32'h0);
        chk("rst0.F_PCADD4", F_PCADD4, 32'h0);
        next_cycle();
        expect_cycle("rst1", 1'b0, 30'h40, 1'b0, 32'h0);

        // Stream from RESET_PC with F_READY high.
        RST = 1'b0; settle();
        expect_cycle("c0", 1'b1, 30'h40, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("c1", 1'b1, 30'h41, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("c2", 1'b1, 30'h42, 1'b1, 32'h104);
        next_cycle(); settle(); expect_cycle("c3", 1'b1, 30'h43, 1'b1, 32'h108);
        next_cycle(); settle(); expect_cycle("c4", 1'b1, 30'h44, 1'b1, 32'h10C);

        // Stall: queue fills, then IREQ holds low.
        next_cycle(); F_READY = 1'b0; settle(); expect_cycle("c5", 1'b1, 30'h45, 1'b1, 32'h110);
        next_cycle(); settle(); expect_cycle("c6", 1'b1, 30'h46, 1'b1, 32'h110);
        next_cycle(); settle(); expect_cycle("c7", 1'b0, 30'h47, 1'b1, 32'h110);
        for (int i = 8; i <= 14; i++) begin
            next_cycle(); settle(); expect_cycle("stall", 1'b0, 30'h47, 1'b1, 32'h110);
        end

        // Single pop frees one slot: exactly one IREQ the following cycle.
        next_cycle(); F_READY = 1'b1; settle(); expect_cycle("c15", 1'b0, 30'h47, 1'b1, 32'h110);
        next_cycle(); F_READY = 1'b0; settle(); expect_cycle("c16", 1'b1, 30'h47, 1'b1, 32'h114);
        next_cycle(); settle(); expect_cycle("c17", 1'b0, 30'h48, 1'b1, 32'h114);

        // Drain and refill with push+pop overlapping; order must be preserved.
        next_cycle(); F_READY = 1'b1; settle(); expect_cycle("c18", 1'b0, 30'h48, 1'b1, 32'h114);
        next_cycle(); settle(); expect_cycle("c19", 1'b1, 30'h48, 1'b1, 32'h118);
        next_cycle(); settle(); expect_cycle("c20", 1'b1, 30'h49, 1'b1, 32'h11C);
        next_cycle(); settle(); expect_cycle("c21", 1'b1, 30'h4A, 1'b1, 32'h120);
        next_cycle(); settle(); expect_cycle("c22", 1'b1, 30'h4B, 1'b1, 32'h124);

        // Three buffered plus one in flight, then redirect to 0x2000.
        next_cycle(); F_READY = 1'b0; settle(); expect_cycle("c23", 1'b1, 30'h4C, 1'b1, 32'h128);
        next_cycle(); REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_2000; settle();
        expect_cycle("redir", 1'b0, 30'h4D, 1'b1, 32'h128);
        next_cycle(); REDIRECT = 1'b0; F_READY = 1'b1; settle();
        expect_cycle("r1", 1'b1, 30'h800, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("r2", 1'b1, 30'h801, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("r3", 1'b1, 30'h802, 1'b1, 32'h2004);
        next_cycle(); settle(); expect_cycle("r4", 1'b1, 30'h803, 1'b1, 32'h2008);

        // Redirect to the top of the address space: PC wraps to zero.
        next_cycle(); REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC; settle();
        expect_cycle("wredir", 1'b0, 30'h804, 1'b1, 32'h200C);
        next_cycle(); REDIRECT = 1'b0; settle();
        expect_cycle("w1", 1'b1, 30'h3FFF_FFFF, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("w2", 1'b1, 30'h0, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("w3", 1'b1, 30'h1, 1'b1, 32'h0000_0000);
        next_cycle(); settle(); expect_cycle("w4", 1'b1, 30'h2, 1'b1, 32'h0000_0004);

        // Reset mid-stream: immediate return to reset values, in-flight word dropped.
        next_cycle(); RST = 1'b1; settle();
        expect_cycle("mrst", 1'b0, 30'h40, 1'b0, 32'h0);
        chk("mrst.F_INSTR", F_INSTR, 32'h0);
        chk("mrst.F_PCADD4", F_PCADD4, 32'h0);
        next_cycle(); RST = 1'b0; settle();
        expect_cycle("m0", 1'b1, 30'h40, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("m1", 1'b1, 30'h41, 1'b0, 32'h0);
        next_cycle(); settle(); expect_cycle("m2", 1'b1, 30'h42, 1'b1, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
